// File: rtl/sdft_line_reader_if.sv
// Purpose: bundles the sample strobe, sliding-DFT core handshake and waterfall line-write port.
// Latency: none, wiring only.
// Backpressure: none here; the core paces updates through sdft_ready, and line writes cannot be stalled.
// Ports: master = sdft_line_reader (drives core requests, line writes, overrun);
//        slave  = environment (ADC strobe, core ready/magnitude, line RAM).
interface sdft_line_reader_if #(
    parameter int DATA_W     = 8,
    parameter int FREQ_W     = 16,
    parameter int LIMIT_BINS = 32,
    parameter int PIX_W      = 8
);
    localparam int BIN_ADDR_W = $clog2(LIMIT_BINS);

    logic [DATA_W-1:0]     sample_in;
    logic                  sample_valid;
    logic [DATA_W-1:0]     sdft_sample;
    logic                  sdft_start;
    logic                  sdft_read;
    logic [BIN_ADDR_W-1:0] sdft_bin_addr;
    logic [FREQ_W-1:0]     sdft_bin_out;
    logic                  sdft_ready;
    logic                  line_wr_en;
    logic [BIN_ADDR_W-1:0] line_wr_addr;
    logic [PIX_W-1:0]      line_wr_data;
    logic                  line_done;
    logic                  overrun;

    modport master (
        input  sample_in, sample_valid, sdft_bin_out, sdft_ready,
        output sdft_sample, sdft_start, sdft_read, sdft_bin_addr,
               line_wr_en, line_wr_addr, line_wr_data, line_done, overrun
    );

    modport slave (
        output sample_in, sample_valid, sdft_bin_out, sdft_ready,
        input  sdft_sample, sdft_start, sdft_read, sdft_bin_addr,
               line_wr_en, line_wr_addr, line_wr_data, line_done, overrun
    );
endinterface

// File: rtl/sdft_line_reader.sv
// Purpose: feeds ADC samples to the sliding-DFT core and, every LINE_EVERY updates, sweeps its bins into a waterfall line.
// Latency: sample strobe to sdft_start 2 cycles when idle; bin k written READ_LAT+1 cycles after its address is presented.
// Backpressure: one-deep pending sample while the core is busy; a further arrival is dropped and flagged on overrun.
// Ports: clk, reset_n (async active-low); bus = sdft_line_reader_if.master (sample in, core start/read/bin port,
//        line write port, line_done and overrun pulses).
module sdft_line_reader #(
    parameter int DATA_W     = 8,
    parameter int FREQ_W     = 16,
    parameter int LIMIT_BINS = 32,
    parameter int PIX_W      = 8,
    parameter int PIX_SHIFT  = 4,
    parameter int LINE_EVERY = 16,
    parameter int READ_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sdft_line_reader_if.master   bus
);
    localparam int BIN_ADDR_W = $clog2(LIMIT_BINS);
    localparam int CNT_W      = $clog2(LINE_EVERY);
    localparam int SWEEP_LEN  = LIMIT_BINS + READ_LAT;
    localparam int SW_W       = $clog2(SWEEP_LEN);
    localparam int PIX_MAX    = (2 ** PIX_W) - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_SKIP,
        ST_BUSY,
        ST_READ_ON,
        ST_SWEEP
    } state_t;

    state_t                state, state_nxt;
    logic                  pend_vld;
    logic [DATA_W-1:0]     pend_dat;
    logic [DATA_W-1:0]     sample_q;
    logic [CNT_W-1:0]      upd_cnt;
    logic [SW_W-1:0]       sw_cnt;
    logic                  wr_en_q;
    logic [BIN_ADDR_W-1:0] wr_addr_q;
    logic [PIX_W-1:0]      wr_data_q;
    logic                  done_q;
    logic                  overrun_q;

    logic                  cnt_wrap;
    logic                  sweep_last;
    logic                  capture;
    logic [SW_W-1:0]       cap_k;
    logic [FREQ_W-1:0]     mag_shr;
    logic [PIX_W-1:0]      pix;
    logic [BIN_ADDR_W-1:0] bin_addr;

    assign cnt_wrap   = (upd_cnt == CNT_W'(LINE_EVERY - 1));
    assign sweep_last = (sw_cnt == SW_W'(SWEEP_LEN - 1));
    // The first READ_LAT sweep cycles only fill the core's read pipeline.
    assign capture    = (state == ST_SWEEP) && (sw_cnt >= SW_W'(READ_LAT));
    assign cap_k      = sw_cnt - SW_W'(READ_LAT);

    assign mag_shr = bus.sdft_bin_out >> PIX_SHIFT;
    assign pix     = (mag_shr > FREQ_W'(PIX_MAX)) ? PIX_W'(PIX_MAX) : mag_shr[PIX_W-1:0];

    // Address tracks the sweep cycle and parks on the last bin while the pipeline drains.
    always_comb begin
        bin_addr = '0;
        if (state == ST_SWEEP) begin
            if (sw_cnt >= SW_W'(LIMIT_BINS - 1)) begin
                bin_addr = BIN_ADDR_W'(LIMIT_BINS - 1);
            end else begin
                bin_addr = sw_cnt[BIN_ADDR_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (pend_vld && bus.sdft_ready) state_nxt = ST_LAUNCH;
            ST_LAUNCH:  state_nxt = ST_SKIP;
            // The core still shows ready in the cycle it takes start; give it one cycle to drop it.
            ST_SKIP:    state_nxt = ST_BUSY;
            ST_BUSY:    if (bus.sdft_ready) state_nxt = cnt_wrap ? ST_READ_ON : ST_IDLE;
            ST_READ_ON: state_nxt = ST_SWEEP;
            ST_SWEEP:   if (sweep_last) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            pend_vld  <= 1'b0;
            pend_dat  <= '0;
            sample_q  <= '0;
            upd_cnt   <= '0;
            sw_cnt    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            overrun_q <= 1'b0;

            // LAUNCH consumes the pending slot, so an arrival that same cycle simply refills it.
            if (state == ST_LAUNCH) begin
                pend_vld <= bus.sample_valid;
                if (bus.sample_valid) begin
                    pend_dat <= bus.sample_in;
                end
            end else if (bus.sample_valid) begin
                if (!pend_vld) begin
                    pend_vld <= 1'b1;
                    pend_dat <= bus.sample_in;
                end else begin
                    overrun_q <= 1'b1;
                end
            end

            if ((state == ST_IDLE) && (state_nxt == ST_LAUNCH)) begin
                sample_q <= pend_dat;
            end

            if ((state == ST_BUSY) && bus.sdft_ready) begin
                upd_cnt <= cnt_wrap ? '0 : upd_cnt + 1'b1;
            end

            sw_cnt <= ((state == ST_SWEEP) && !sweep_last) ? sw_cnt + 1'b1 : '0;

            wr_en_q <= capture;
            if (capture) begin
                wr_addr_q <= cap_k[BIN_ADDR_W-1:0];
                wr_data_q <= pix;
            end

            done_q <= (state == ST_SWEEP) && sweep_last;
        end
    end

    assign bus.sdft_sample   = sample_q;
    assign bus.sdft_start    = (state == ST_LAUNCH);
    assign bus.sdft_read     = (state == ST_READ_ON) || (state == ST_SWEEP);
    assign bus.sdft_bin_addr = bin_addr;
    assign bus.line_wr_en    = wr_en_q;
    assign bus.line_wr_addr  = wr_addr_q;
    assign bus.line_wr_data  = wr_data_q;
    assign bus.line_done     = done_q;
    assign bus.overrun       = overrun_q;
endmodule
